// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_REDIRECT   = 2'd2,
      ST_MEM_WAIT   = 2'd3
   } hazard_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one execute-stage ALU operand.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REGISTER_ADDRESS_WIDTH = 5
) (
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs_e_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w_i,
   input  logic                              reg_write_m_i,
   input  logic                              reg_write_w_i,
   output logic [1:0]                        fwd_o
);

   // The memory stage holds the younger result, so it wins over writeback.
   always_comb begin
      fwd_o = FWD_RF;
      if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
         fwd_o = FWD_M;
      end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
         fwd_o = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage RV32I hazard controller: forwarding, stall/flush generation,
// cycle classification and saturating stall/flush/memory-wait statistics.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REGISTER_ADDRESS_WIDTH = 5,
   parameter int CNT_WIDTH              = 32,
   parameter int MEM_TIMEOUT            = 256
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
   input  logic [1:0]                        ResultSrcE_i,
   input  logic                              PCSrcE_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
   input  logic                              RegWriteM_i,
   input  logic                              RegWriteW_i,
   input  logic                              MemReqM_i,
   input  logic                              MemReadyM_i,
   output logic [1:0]                        ForwardAE_o,
   output logic [1:0]                        ForwardBE_o,
   output logic                              StallF_o,
   output logic                              StallD_o,
   output logic                              StallE_o,
   output logic                              StallM_o,
   output logic                              FlushD_o,
   output logic                              FlushE_o,
   output logic                              FlushW_o,
   output logic [1:0]                        State_o,
   output logic [CNT_WIDTH-1:0]              StallCnt_o,
   output logic [CNT_WIDTH-1:0]              FlushCnt_o,
   output logic [CNT_WIDTH-1:0]              LastWait_o,
   output logic                              MemErr_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);

   hazard_state_e              state_q, state_d;
   logic [CNT_WIDTH-1:0]       stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]       flush_cnt_q, flush_cnt_d;
   logic [CNT_WIDTH-1:0]       wait_cnt_q, wait_cnt_d;
   logic [CNT_WIDTH-1:0]       last_wait_q, last_wait_d;
   logic                       mem_err_q, mem_err_d;
   logic [1:0]                 fwd_a, fwd_b;
   logic                       mem_stall, lw_stall;

   hazard_fwd_sel #(.REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_fwd_a (
      .rs_e_i        (Rs1E_i),
      .rd_m_i        (RdM_i),
      .rd_w_i        (RdW_i),
      .reg_write_m_i (RegWriteM_i),
      .reg_write_w_i (RegWriteW_i),
      .fwd_o         (fwd_a)
   );

   hazard_fwd_sel #(.REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_fwd_b (
      .rs_e_i        (Rs2E_i),
      .rd_m_i        (RdM_i),
      .rd_w_i        (RdW_i),
      .reg_write_m_i (RegWriteM_i),
      .reg_write_w_i (RegWriteW_i),
      .fwd_o         (fwd_b)
   );

   // Memory wait outranks redirect: E is held, so the redirect replays on release.
   always_comb begin
      mem_stall = MemReqM_i && !MemReadyM_i;
      lw_stall  = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                  ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
      if (mem_stall)      state_d = ST_MEM_WAIT;
      else if (PCSrcE_i)  state_d = ST_REDIRECT;
      else if (lw_stall)  state_d = ST_LOAD_STALL;
      else                state_d = ST_RUN;
   end

   always_comb begin
      ForwardAE_o = fwd_a;
      ForwardBE_o = fwd_b;
      StallF_o    = 1'b0;
      StallD_o    = 1'b0;
      StallE_o    = 1'b0;
      StallM_o    = 1'b0;
      FlushD_o    = 1'b0;
      FlushE_o    = 1'b0;
      FlushW_o    = 1'b0;
      case (state_d)
         ST_MEM_WAIT: begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
         end
         ST_REDIRECT: begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
         end
         ST_LOAD_STALL: begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
         end
         default: ;
      endcase
      // Drain bubbles through the pipeline while reset is held.
      if (!rst_n_i) begin
         ForwardAE_o = FWD_RF;
         ForwardBE_o = FWD_RF;
         StallF_o    = 1'b0;
         StallD_o    = 1'b0;
         StallE_o    = 1'b0;
         StallM_o    = 1'b0;
         FlushD_o    = 1'b1;
         FlushE_o    = 1'b1;
         FlushW_o    = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      wait_cnt_d  = '0;
      last_wait_d = last_wait_q;
      mem_err_d   = mem_err_q;
      if (((state_d == ST_MEM_WAIT) || (state_d == ST_LOAD_STALL)) && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if ((state_d == ST_REDIRECT) && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
      if (state_d == ST_MEM_WAIT) begin
         wait_cnt_d = (wait_cnt_q != CNT_MAX) ? wait_cnt_q + CNT_ONE : wait_cnt_q;
         if (wait_cnt_q >= TIMEOUT_LAST) begin
            mem_err_d = 1'b1;
         end
      end else if (wait_cnt_q != '0) begin
         last_wait_d = wait_cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
         last_wait_q <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         last_wait_q <= last_wait_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign State_o    = state_q;
   assign StallCnt_o = stall_cnt_q;
   assign FlushCnt_o = flush_cnt_q;
   assign LastWait_o = last_wait_q;
   assign MemErr_o   = mem_err_q;

endmodule
